// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - EX/MEM pipeline register, data-memory handshake and MEM/WB register
// Loads and stores hold the M slot until the memory handshake completes; everything else passes in one cycle.
module mem_access_unit #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_e,
  input  logic               reg_write_e,
  input  logic [1:0]         result_src_e,
  input  logic               mem_write_e,
  input  logic [2:0]         funct3_e,
  input  logic [D_WIDTH-1:0] alu_result_e,
  input  logic [D_WIDTH-1:0] write_data_e,
  input  logic [4:0]         rd_e,
  input  logic [D_WIDTH-1:0] pc_plus_4e,
  output logic               stall_o,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic               dmem_we,
  output logic [D_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_rsp_valid,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  output logic               valid_w,
  output logic               reg_write_w,
  output logic [1:0]         result_src_w,
  output logic [D_WIDTH-1:0] alu_result_w,
  output logic [D_WIDTH-1:0] read_data_w,
  output logic [D_WIDTH-1:0] pc_plus_4w,
  output logic [4:0]         rd_w,
  output logic               misaligned_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_valid_m;
  logic               r_reg_write_m;
  logic [1:0]         r_result_src_m;
  logic               r_mem_write_m;
  logic [2:0]         r_funct3_m;
  logic [D_WIDTH-1:0] r_alu_m;
  logic [D_WIDTH-1:0] r_wdata_m;
  logic [4:0]         r_rd_m;
  logic [D_WIDTH-1:0] r_pc4_m;

  logic               w_load_m;
  logic               w_store_m;
  logic               w_mis_m;
  logic               w_mem_e;
  logic               w_mis_e;
  logic               w_retire;
  logic [1:0]         w_off;
  logic [D_WIDTH-1:0] w_lane;
  logic [D_WIDTH-1:0] w_load_data;

  // Size code 00 = byte, 01 = half, anything else = word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || (size[1] | (size == 2'b11)) && (off != 2'b00);
  endfunction

  assign w_load_m  = r_valid_m & (r_result_src_m == 2'b01);
  assign w_store_m = r_valid_m & r_mem_write_m;
  assign w_mis_m   = (w_load_m | w_store_m) & is_misaligned(r_funct3_m[1:0], r_alu_m[1:0]);
  assign w_mem_e   = valid_e & ((result_src_e == 2'b01) | mem_write_e);
  assign w_mis_e   = w_mem_e & is_misaligned(funct3_e[1:0], alu_result_e[1:0]);
  assign w_retire  = ~stall_o;
  assign w_off     = r_alu_m[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    dmem_req_valid = 1'b0;
    stall_o        = 1'b0;
    case (r_state)
      S_REQ: begin
        dmem_req_valid = 1'b1;
        stall_o        = ~(dmem_req_ready & w_store_m);
      end
      S_RSP:   stall_o = ~dmem_rsp_valid;
      default: stall_o = 1'b0;
    endcase
    if (~stall_o)
      w_next = (w_mem_e & ~w_mis_e) ? S_REQ : S_IDLE;
    else if ((r_state == S_REQ) && dmem_req_ready)
      w_next = S_RSP;
  end

  assign dmem_addr = {r_alu_m[D_WIDTH-1:2], 2'b00};
  assign dmem_we   = w_store_m;
  assign w_lane    = dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    dmem_be     = 4'b1111;
    dmem_wdata  = r_wdata_m;
    w_load_data = dmem_rdata;
    case (r_funct3_m[1:0])
      2'b00: begin
        dmem_be     = 4'b0001 << w_off;
        dmem_wdata  = {4{r_wdata_m[7:0]}};
        w_load_data = r_funct3_m[2] ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      end
      2'b01: begin
        dmem_be     = 4'b0011 << w_off;
        dmem_wdata  = {2{r_wdata_m[15:0]}};
        w_load_data = r_funct3_m[2] ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_m      <= 1'b0;
      r_reg_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
      r_mem_write_m  <= 1'b0;
      r_funct3_m     <= 3'd0;
      r_alu_m        <= '0;
      r_wdata_m      <= '0;
      r_rd_m         <= 5'd0;
      r_pc4_m        <= '0;
      valid_w        <= 1'b0;
      reg_write_w    <= 1'b0;
      result_src_w   <= 2'b00;
      alu_result_w   <= '0;
      read_data_w    <= '0;
      pc_plus_4w     <= '0;
      rd_w           <= 5'd0;
      misaligned_o   <= 1'b0;
    end else if (w_retire) begin
      r_valid_m      <= valid_e;
      r_reg_write_m  <= reg_write_e;
      r_result_src_m <= result_src_e;
      r_mem_write_m  <= mem_write_e;
      r_funct3_m     <= funct3_e;
      r_alu_m        <= alu_result_e;
      r_wdata_m      <= write_data_e;
      r_rd_m         <= rd_e;
      r_pc4_m        <= pc_plus_4e;
      // A misaligned access leaves the pipe as a bubble flagged by misaligned_o.
      valid_w        <= r_valid_m & ~w_mis_m;
      reg_write_w    <= r_valid_m & r_reg_write_m & ~w_mis_m;
      result_src_w   <= r_result_src_m;
      alu_result_w   <= r_alu_m;
      read_data_w    <= (w_load_m & ~w_mis_m) ? w_load_data : '0;
      pc_plus_4w     <= r_pc4_m;
      rd_w           <= r_rd_m;
      misaligned_o   <= w_mis_m;
    end else begin
      valid_w        <= 1'b0;
      reg_write_w    <= 1'b0;
      misaligned_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Table-driven load/store vectors, directed corner sequences and a randomized run against a queue model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e, reg_write_e, mem_write_e;
  logic [1:0]  result_src_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_result_e, write_data_e, pc_plus_4e;
  logic [4:0]  rd_e;
  logic        stall_o, dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic        valid_w, reg_write_w, misaligned_o;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w, read_data_w, pc_plus_4w;
  logic [4:0]  rd_w;

  logic        use_fixed;
  logic [31:0] fixed_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.D_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .reg_write_e(reg_write_e),
    .result_src_e(result_src_e), .mem_write_e(mem_write_e), .funct3_e(funct3_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
    .pc_plus_4e(pc_plus_4e), .stall_o(stall_o), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .valid_w(valid_w), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w), .alu_result_w(alu_result_w), .read_data_w(read_data_w),
    .pc_plus_4w(pc_plus_4w), .rd_w(rd_w), .misaligned_o(misaligned_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always_comb dmem_rdata = use_fixed ? fixed_rdata : mem_word(dmem_addr);

  // Reference rules, stated in terms of access size and byte offset.
  function automatic int acc_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % acc_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = acc_bytes(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = acc_bytes(f3);
    if (n == 1) return (d % 256) * 32'h01010101;
    if (n == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    longint v, m;
    int n;
    n = acc_bytes(f3);
    if (n == 4) return w;
    m = longint'(1) << (8 * n);
    v = (longint'(w) >> (8 * (a % 4))) % m;
    if (!f3[2] && v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_e = 0; reg_write_e = 0; result_src_e = 0; mem_write_e = 0; funct3_e = 0;
    alu_result_e = 0; write_data_e = 0; rd_e = 0; pc_plus_4e = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; drive_idle(); dmem_req_ready = 0; dmem_rsp_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    string       name;
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;      // store data or load word
    int          rdy_d;
    int          rsp_d;
    logic [3:0]  exp_be;
    logic [31:0] exp_val;   // dmem_wdata for stores, read_data_w for loads
  } vec_t;

  task automatic run_mem(input vec_t v);
    int  nst, hs;
    logic done;
    nst = 0; hs = 0; done = 0;
    @(negedge clk);
    drive_idle();
    valid_e = 1; funct3_e = v.f3; alu_result_e = v.addr; rd_e = 5'd9;
    pc_plus_4e = 32'h0000_0104;
    if (v.is_store) begin mem_write_e = 1; write_data_e = v.data; end
    else begin reg_write_e = 1; result_src_e = 2'b01; end
    use_fixed = 1; fixed_rdata = v.data;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive_idle();
      dmem_req_ready = (c >= v.rdy_d);
      dmem_rsp_valid = !v.is_store && (c >= v.rdy_d + 1 + v.rsp_d);
      #1;
      if (dmem_req_valid && dmem_req_ready) begin
        hs++;
        chk({v.name, "_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
        chk({v.name, "_we_be"}, {27'd0, dmem_we, dmem_be}, {27'd0, v.is_store, v.exp_be});
        if (v.is_store) chk({v.name, "_wdata"}, dmem_wdata, v.exp_val);
      end
      if (!stall_o) begin done = 1; break; end
      nst++;
    end
    chk({v.name, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    chk({v.name, "_hs"}, hs, 32'd1);
    chk({v.name, "_stalls"}, nst, v.is_store ? v.rdy_d : v.rdy_d + 1 + v.rsp_d);
    chk({v.name, "_wb"}, {30'd0, valid_w, reg_write_w}, {30'd0, 1'b1, !v.is_store});
    if (!v.is_store) chk({v.name, "_rdata"}, read_data_w, v.exp_val);
    use_fixed = 0;
  endtask

  typedef struct {
    logic        mis;
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu, pc4, rdat;
  } wexp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  vec_t  vt[9];

  initial begin
    rst = 1; use_fixed = 0; fixed_rdata = 0;
    drive_idle(); dmem_req_ready = 0; dmem_rsp_valid = 0;
    vt[0] = '{"sb_bp",   1, 3'b000, 32'h0000_1002, 32'h0000_00AB, 3, 0, 4'b0100, 32'hABAB_ABAB};
    vt[1] = '{"sh",      1, 3'b001, 32'h0000_1002, 32'h1234_CDEF, 0, 0, 4'b1100, 32'hCDEF_CDEF};
    vt[2] = '{"sw",      1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1, 0, 4'b1111, 32'hDEAD_BEEF};
    vt[3] = '{"lb",      0, 3'b000, 32'h0000_2001, 32'h0000_F000, 0, 1, 4'b0010, 32'hFFFF_FFF0};
    vt[4] = '{"lbu",     0, 3'b100, 32'h0000_2001, 32'h0000_F000, 0, 1, 4'b0010, 32'h0000_00F0};
    vt[5] = '{"lh",      0, 3'b001, 32'h0000_4002, 32'h8000_0000, 2, 0, 4'b1100, 32'hFFFF_8000};
    vt[6] = '{"lhu",     0, 3'b101, 32'h0000_4002, 32'h8000_0000, 0, 3, 4'b1100, 32'h0000_8000};
    vt[7] = '{"lw",      0, 3'b010, 32'h0000_5000, 32'h1234_5678, 1, 1, 4'b1111, 32'h1234_5678};
    vt[8] = '{"lb_hi",   0, 3'b000, 32'h0000_2003, 32'h7F00_0000, 0, 0, 4'b1000, 32'h0000_007F};

    #2;
    chk("rst_wb", {27'd0, valid_w, reg_write_w, misaligned_o, dmem_req_valid, stall_o}, 32'd0);
    chk("rst_data", alu_result_w | read_data_w | pc_plus_4w | {27'd0, rd_w} | {30'd0, result_src_w}, 32'd0);
    @(negedge clk); rst = 0;

    // ADD passes through in one M cycle.
    @(negedge clk);
    valid_e = 1; reg_write_e = 1; alu_result_e = 32'h5; rd_e = 5'd3; dmem_req_ready = 1;
    #1 chk("add_stall0", 32'(stall_o), 32'd0);
    @(negedge clk);
    drive_idle();
    #1 chk("add_stall1", 32'(stall_o), 32'd0);
    @(negedge clk);
    chk("add_wb", {valid_w, reg_write_w, 25'd0, rd_w}, {1'b1, 1'b1, 25'd0, 5'd3});
    chk("add_alu", alu_result_w, 32'h5);
    chk("add_rdata", read_data_w, 32'h0);
    @(negedge clk);
    chk("add_bubble", 32'(valid_w), 32'd0);

    for (int i = 0; i < 9; i++) run_mem(vt[i]);

    // Misaligned word load: no request, no stall, one-cycle flag.
    @(negedge clk);
    valid_e = 1; reg_write_e = 1; result_src_e = 2'b01; funct3_e = 3'b010;
    alu_result_e = 32'h0000_3002; dmem_req_ready = 1;
    @(negedge clk);
    drive_idle();
    #1 chk("mis_noreq", {30'd0, dmem_req_valid, stall_o}, 32'd0);
    @(negedge clk);
    chk("mis_flag", {29'd0, misaligned_o, valid_w, reg_write_w}, {29'd0, 3'b100});
    @(negedge clk);
    chk("mis_pulse", 32'(misaligned_o), 32'd0);

    // Back-to-back sw then lh with no gap between them.
    @(negedge clk);
    valid_e = 1; mem_write_e = 1; funct3_e = 3'b010; alu_result_e = 32'h0000_4000;
    write_data_e = 32'h0BAD_F00D; dmem_req_ready = 1; dmem_rsp_valid = 0;
    use_fixed = 1; fixed_rdata = 32'h8000_0000;
    @(negedge clk);
    drive_idle();
    valid_e = 1; reg_write_e = 1; result_src_e = 2'b01; funct3_e = 3'b001;
    alu_result_e = 32'h0000_4002; rd_e = 5'd7;
    #1 chk("b2b_st_req", {29'd0, dmem_req_valid, dmem_we, stall_o}, {29'd0, 3'b110});
    @(negedge clk);
    drive_idle();
    #1 chk("b2b_ld_req", {29'd0, dmem_req_valid, dmem_we, stall_o}, {29'd0, 3'b101});
    chk("b2b_st_wb", {30'd0, valid_w, reg_write_w}, {30'd0, 2'b10});
    @(negedge clk);
    dmem_rsp_valid = 1;
    #1 chk("b2b_rsp_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    dmem_rsp_valid = 0;
    chk("b2b_ld_wb", {valid_w, reg_write_w, 25'd0, rd_w}, {2'b11, 25'd0, 5'd7});
    chk("b2b_ld_data", read_data_w, 32'hFFFF_8000);

    // Reset while waiting for a response; the late response must be ignored.
    @(negedge clk);
    valid_e = 1; reg_write_e = 1; result_src_e = 2'b01; funct3_e = 3'b010;
    alu_result_e = 32'h0000_6000; dmem_req_ready = 1;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1 chk("rsp_wait", 32'(stall_o), 32'd1);
    rst = 1;
    #1 chk("rst_async", {30'd0, stall_o, dmem_req_valid}, 32'd0);
    @(negedge clk);
    rst = 0; dmem_rsp_valid = 1;
    #1 chk("rst_idle", {30'd0, stall_o, dmem_req_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ignored", {30'd0, valid_w, reg_write_w}, 32'd0);
    dmem_rsp_valid = 0; use_fixed = 0;

    // Randomized run against the queue model.
    do_reset();
    begin
      logic acc;
      int   n_rand;
      acc = 1;
      n_rand = 0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
        @(negedge clk);
        if (valid_w || misaligned_o) begin
          if (wq.size() == 0) chk("rnd_unexpected", 32'd1, 32'd0);
          else begin
            wexp_t e;
            e = wq.pop_front();
            if (e.mis) chk("rnd_mis", {29'd0, misaligned_o, valid_w, reg_write_w}, {29'd0, 3'b100});
            else begin
              chk("rnd_ctl", {misaligned_o, valid_w, reg_write_w, result_src_w, 22'd0, rd_w},
                  {1'b0, 1'b1, e.rw, e.rs, 22'd0, e.rd});
              chk("rnd_alu", alu_result_w, e.alu);
              chk("rnd_pc4", pc_plus_4w, e.pc4);
              chk("rnd_rdata", read_data_w, e.rdat);
            end
          end
        end
        if (acc) begin
          if (cyc >= 1100) drive_idle();
          else begin
            int kind;
            kind = $urandom_range(0, 2);
            valid_e = ($urandom_range(0, 7) != 0);
            reg_write_e = $urandom_range(0, 1);
            funct3_e = 3'($urandom);
            alu_result_e = $urandom;
            write_data_e = $urandom;
            rd_e = 5'($urandom);
            pc_plus_4e = $urandom;
            mem_write_e = (kind == 2);
            result_src_e = (kind == 1) ? 2'b01 : ($urandom_range(0, 1) ? 2'b10 : 2'b00);
            if (valid_e) begin
              wexp_t e;
              logic  is_mem;
              is_mem = (kind != 0);
              e.mis = is_mem && model_mis(funct3_e, alu_result_e);
              e.rw = reg_write_e; e.rs = result_src_e; e.rd = rd_e;
              e.alu = alu_result_e; e.pc4 = pc_plus_4e;
              e.rdat = (kind == 1) ? model_load(funct3_e, alu_result_e, mem_word(alu_result_e)) : 32'd0;
              wq.push_back(e);
              n_rand++;
              if (is_mem && !e.mis) begin
                rexp_t r;
                r.we = (kind == 2); r.addr = {alu_result_e[31:2], 2'b00};
                r.be = model_be(funct3_e, alu_result_e);
                r.wdata = model_wdata(funct3_e, write_data_e);
                rq.push_back(r);
              end
            end
          end
        end
        dmem_req_ready = ($urandom_range(0, 2) != 0);
        dmem_rsp_valid = ($urandom_range(0, 2) != 0);
        #1;
        if (dmem_req_valid && dmem_req_ready) begin
          if (rq.size() == 0) chk("rnd_req_unexpected", 32'd1, 32'd0);
          else begin
            rexp_t r;
            r = rq.pop_front();
            chk("rnd_req_addr", dmem_addr, r.addr);
            chk("rnd_req_we_be", {27'd0, dmem_we, dmem_be}, {27'd0, r.we, r.be});
            if (r.we) chk("rnd_req_wdata", dmem_wdata, r.wdata);
          end
        end
        acc = !stall_o;
      end
      chk("rnd_w_drained", wq.size(), 32'd0);
      chk("rnd_req_drained", rq.size(), 32'd0);
      if (n_rand < 100) chk("rnd_volume", 32'(n_rand), 32'd100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
